// File: rtl/bnn_sequencer_pkg.sv
// Shared types and function codes for the Execute-stage BNN sequencer.
// Holds the FSM state encoding and the BnnFuncE opcode values.
package skylark_bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bnn_state_t;

    localparam logic [1:0] BNN_XNPC     = 2'b00;
    localparam logic [1:0] BNN_XNPC_ACC = 2'b01;
    localparam logic [1:0] BNN_THRESH   = 2'b10;
    localparam logic [1:0] BNN_CLR      = 2'b11;

endpackage

// File: rtl/bnn_sequencer_popcount.sv
// Purpose: population count of one W-bit chunk.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module bnn_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W+1);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/bnn_sequencer.sv
// Purpose: sequences XNOR-popcount / accumulate / threshold / clear for the Execute-stage BNN path.
// Latency: func 00/01 take 32/CHUNK_W+1 cycles to DONE, func 10/11 take one cycle.
// Backpressure: BnnStallE holds the pipeline from the start cycle until the DONE cycle.
module bnn_sequencer
    import skylark_bnn_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int ACC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BnnStartE,
    input  logic [1:0]  BnnFuncE,
    input  logic [31:0] OpA_E,
    input  logic [31:0] OpB_E,
    input  logic        FlushE,
    output logic [31:0] BNNResult,
    output logic        BnnStallE,
    output logic        BnnDoneE
);

    localparam int N_CHUNK = 32 / CHUNK_W;
    localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int PC_W    = $clog2(CHUNK_W + 1);
    localparam int SUM_W   = ACC_W + 1;

    bnn_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [1:0]         func;
    logic [5:0]         psum;
    logic [ACC_W-1:0]   acc;
    logic [31:0]        result;

    logic [31:0]        xnor_bits;
    logic [31:0]        xnor_shifted;
    logic [CHUNK_W-1:0] chunk;
    logic [PC_W-1:0]    chunk_pc;
    logic [5:0]         psum_next;
    logic [SUM_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_sat;
    logic               last_chunk;
    logic               thresh_hit;

    // LSB chunk first: the counter selects which slice of the XNOR word is counted this cycle.
    assign xnor_bits    = ~(op_a ^ op_b);
    assign xnor_shifted = xnor_bits >> (int'(cnt) * CHUNK_W);
    assign chunk        = xnor_shifted[CHUNK_W-1:0];

    bnn_popcount #(.W(CHUNK_W)) u_popcount (
        .bits  (chunk),
        .count (chunk_pc)
    );

    assign psum_next  = psum + 6'(chunk_pc);
    assign last_chunk = (cnt == CNT_W'(N_CHUNK - 1));

    // One extra bit of headroom so overflow is visible and clamps to all-ones.
    assign acc_sum    = {1'b0, acc} + SUM_W'(psum_next);
    assign acc_sat    = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign thresh_hit = (acc >= OpB_E[ACC_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            func   <= BNN_XNPC;
            psum   <= '0;
            acc    <= '0;
            result <= '0;
        end else if (FlushE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (BnnStartE) begin
                        op_a <= OpA_E;
                        op_b <= OpB_E;
                        func <= BnnFuncE;
                        cnt  <= '0;
                        psum <= '0;
                        case (BnnFuncE)
                            BNN_THRESH: begin
                                result <= {31'b0, thresh_hit};
                                state  <= DONE;
                            end
                            BNN_CLR: begin
                                acc    <= '0;
                                result <= '0;
                                state  <= DONE;
                            end
                            default: state <= RUN;
                        endcase
                    end
                end
                RUN: begin
                    psum <= psum_next;
                    cnt  <= cnt + 1'b1;
                    if (last_chunk) begin
                        state <= DONE;
                        if (func == BNN_XNPC_ACC) begin
                            acc    <= acc_sat;
                            result <= 32'(acc_sat);
                        end else begin
                            result <= 32'(psum_next);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mealy stall so the instruction is held in its very first Execute cycle.
    assign BnnStallE = ~FlushE & (((state == IDLE) & BnnStartE) | (state == RUN));
    assign BnnDoneE  = ~FlushE & (state == DONE);
    assign BNNResult = result;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Drives three sequencer configurations (default, ACC_W=6, CHUNK_W=32) against a
// per-instance reference model of accumulator and result register.
module tb_bnn_sequencer;

    logic        clk;
    logic        rst   [3];
    logic        start [3];
    logic [1:0]  fn    [3];
    logic [31:0] opa   [3];
    logic [31:0] opb   [3];
    logic        flush [3];
    logic [31:0] res   [3];
    logic        stl   [3];
    logic        dn    [3];

    int          tests;
    int          fails;
    int unsigned macc   [3];
    logic [31:0] mres   [3];
    int unsigned accmax [3];
    int          chunkw [3];

    bnn_sequencer #(.CHUNK_W(8), .ACC_W(16)) dut0 (
        .clk(clk), .reset(rst[0]), .BnnStartE(start[0]), .BnnFuncE(fn[0]),
        .OpA_E(opa[0]), .OpB_E(opb[0]), .FlushE(flush[0]),
        .BNNResult(res[0]), .BnnStallE(stl[0]), .BnnDoneE(dn[0])
    );

    bnn_sequencer #(.CHUNK_W(8), .ACC_W(6)) dut1 (
        .clk(clk), .reset(rst[1]), .BnnStartE(start[1]), .BnnFuncE(fn[1]),
        .OpA_E(opa[1]), .OpB_E(opb[1]), .FlushE(flush[1]),
        .BNNResult(res[1]), .BnnStallE(stl[1]), .BnnDoneE(dn[1])
    );

    bnn_sequencer #(.CHUNK_W(32), .ACC_W(16)) dut2 (
        .clk(clk), .reset(rst[2]), .BnnStartE(start[2]), .BnnFuncE(fn[2]),
        .OpA_E(opa[2]), .OpB_E(opb[2]), .FlushE(flush[2]),
        .BNNResult(res[2]), .BnnStallE(stl[2]), .BnnDoneE(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // One instruction sitting in Execute: start held until done, optional flush at cycle offset flush_at.
    task automatic do_op(input int d, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int flush_at);
        int          lat;
        int unsigned pc;
        int unsigned nacc;
        logic [31:0] exp;
        lat  = (f <= 2'd1) ? (32 / chunkw[d]) + 1 : 1;
        pc   = $countones(~(a ^ b));
        nacc = macc[d];
        case (f)
            2'd0: exp = pc;
            2'd1: begin
                nacc = (macc[d] + pc > accmax[d]) ? accmax[d] : macc[d] + pc;
                exp  = nacc;
            end
            2'd2: exp = (macc[d] >= (b & accmax[d])) ? 32'd1 : 32'd0;
            default: begin
                nacc = 0;
                exp  = 0;
            end
        endcase
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start[d] = 1'b1;
                fn[d]    = f;
                opa[d]   = a;
                opb[d]   = b;
            end
            flush[d] = (k == flush_at);
            #1;
            if (k == flush_at) begin
                chk("flush_stall", d, 32'(stl[d]), 32'd0);
                chk("flush_done", d, 32'(dn[d]), 32'd0);
                @(negedge clk);
                flush[d] = 1'b0;
                start[d] = 1'b0;
                #1;
                chk("post_flush_stall", d, 32'(stl[d]), 32'd0);
                chk("post_flush_done", d, 32'(dn[d]), 32'd0);
                chk("post_flush_result", d, res[d], mres[d]);
                return;
            end
            if (k < lat) begin
                chk("stall", d, 32'(stl[d]), 32'd1);
                chk("no_done", d, 32'(dn[d]), 32'd0);
            end else begin
                chk("done_stall", d, 32'(stl[d]), 32'd0);
                chk("done", d, 32'(dn[d]), 32'd1);
                chk("result", d, res[d], exp);
                start[d] = 1'b0;
                macc[d]  = nacc;
                mres[d]  = exp;
            end
        end
    endtask

    task automatic check_idle_outputs(input int d, input logic [31:0] exp_res);
        chk("idle_result", d, res[d], exp_res);
        chk("idle_stall", d, 32'(stl[d]), 32'd0);
        chk("idle_done", d, 32'(dn[d]), 32'd0);
    endtask

    initial begin
        int          d;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          fa;

        tests = 0;
        fails = 0;
        accmax[0] = 65535; accmax[1] = 63; accmax[2] = 65535;
        chunkw[0] = 8;     chunkw[1] = 8;  chunkw[2] = 32;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; fn[i] = 2'b00;
            opa[i] = '0; opb[i] = '0; flush[i] = 1'b0;
            macc[i] = 0; mres[i] = '0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_idle_outputs(i, 32'd0);

        // Directed: threshold after reset, XNOR popcounts, accumulate/threshold/clear.
        do_op(0, 2'd2, 32'h0, 32'd0, -1);
        chk("thresh_after_reset", 0, res[0], 32'd1);
        do_op(0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("xnpc_all_ones", 0, res[0], 32'd32);
        do_op(0, 2'd0, 32'h0000_FFFF, 32'h0, -1);
        chk("xnpc_half", 0, res[0], 32'd16);
        do_op(0, 2'd1, 32'h0, 32'h0, -1);
        do_op(0, 2'd1, 32'h0, 32'h0, -1);
        chk("acc_64", 0, res[0], 32'd64);
        do_op(0, 2'd2, 32'h0, 32'd64, -1);
        chk("thresh_64", 0, res[0], 32'd1);
        do_op(0, 2'd2, 32'h0, 32'd65, -1);
        chk("thresh_65", 0, res[0], 32'd0);
        do_op(0, 2'd3, 32'h0, 32'h0, -1);
        chk("clear", 0, res[0], 32'd0);
        do_op(0, 2'd2, 32'h0, 32'd1, -1);
        chk("thresh_after_clear", 0, res[0], 32'd0);

        // Saturation with a 6-bit accumulator.
        do_op(1, 2'd1, 32'h0, 32'h0, -1);
        chk("sat_first", 1, res[1], 32'd32);
        do_op(1, 2'd1, 32'h0, 32'h0, -1);
        chk("sat_second", 1, res[1], 32'd63);
        do_op(1, 2'd1, 32'h0, 32'h0, -1);
        chk("sat_hold", 1, res[1], 32'd63);

        // Flush two cycles into an accumulate: acc must stay at 32.
        do_op(0, 2'd1, 32'h0, 32'h0, -1);
        do_op(0, 2'd1, 32'h0, 32'h0, 2);
        chk("flush_keeps_result", 0, res[0], 32'd32);
        do_op(0, 2'd2, 32'h0, 32'd33, -1);
        chk("flush_acc_33", 0, res[0], 32'd0);
        do_op(0, 2'd2, 32'h0, 32'd32, -1);
        chk("flush_acc_32", 0, res[0], 32'd1);

        // Single-chunk configuration, back to back.
        do_op(2, 2'd0, 32'h1234_5678, 32'h1234_5678, -1);
        chk("wide_b2b_first", 2, res[2], 32'd32);
        do_op(2, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, -1);
        chk("wide_b2b_second", 2, res[2], 32'd0);

        // Reset in the middle of an accumulate clears acc (currently 32).
        @(negedge clk);
        start[0] = 1'b1; fn[0] = 2'd1; opa[0] = '0; opb[0] = '0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1; start[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        macc[0] = 0; mres[0] = '0;
        check_idle_outputs(0, 32'd0);
        do_op(0, 2'd2, 32'h0, 32'd1, -1);
        chk("reset_clears_acc", 0, res[0], 32'd0);

        // Randomized mix across all three configurations.
        for (int i = 0; i < 80; i++) begin
            d = $urandom_range(0, 2);
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = ~a ^ (32'h1 << $urandom_range(0, 31));
            if (f == 2'd2) b = {b[31:16], 16'($urandom_range(0, macc[d] + 2))};
            lat = (f <= 2'd1) ? (32 / chunkw[d]) + 1 : 1;
            fa  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
            do_op(d, f, a, b, fa);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
